step_sequencer: RTL and testbench

Parametrised successor to the drum-pattern datapath. It stores one STEPS-bit pattern per channel for NUM_CH channels, along with a tempo register and a loop-length register. It runs its own step counter, advanced by an external tempo tick, under a run/pause/stop state machine, and emits registered per-channel trigger pulses and gates. It sits between the front-panel control FSM (load strobes, play/stop) and the tone/sample generators; the tempo divider consumes bpm and returns step_tick.

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_if.sv | 42 ++++
 rtl/seq_step_counter.sv | 60 ++++++
 rtl/step_sequencer.sv | 149 ++++++++++++++
 tb/tb_step_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the step sequencer: FSM state encoding, the
// step-index width helper and the tempo value loaded at reset.
package seq_pkg;

  // Tempo register value after reset.
  localparam int DEFAULT_BPM = 120;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seq_state_e;

  // Width of a step index for a pattern of the given length (at least 1 bit).
  function automatic int step_w(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/seq_if.sv
// Control/status bundle between the front-panel controller (master) and the
// step sequencer (slave).
//   sel/ld_*        : load data and load strobes for patterns, tempo, length
//   play/stop       : run level and stop pulse
//   step_tick       : one-cycle step pulse from the tempo divider
//   mute            : per-channel mute levels
//   trig/gate       : per-channel step pulse / step-long level
//   step/bar_done   : current step index and wrap pulse
//   bpm/running     : tempo register and RUN indicator
interface seq_if import seq_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int STEPS  = 8,
  parameter int BPM_W  = 8
);
  localparam int STEP_W = step_w(STEPS);

  logic [STEPS-1:0]  sel;
  logic [NUM_CH-1:0] ld_ch;
  logic              ld_bpm;
  logic              ld_len;
  logic              play;
  logic              stop;
  logic              step_tick;
  logic [NUM_CH-1:0] mute;
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] gate;
  logic [STEP_W-1:0] step;
  logic              bar_done;
  logic [BPM_W-1:0]  bpm;
  logic              running;

  modport master (
    output sel, ld_ch, ld_bpm, ld_len, play, stop, step_tick, mute,
    input  trig, gate, step, bar_done, bpm, running
  );

  modport slave (
    input  sel, ld_ch, ld_bpm, ld_len, play, stop, step_tick, mute,
    output trig, gate, step, bar_done, bpm, running
  );

endinterface

// File: rtl/seq_step_counter.sv
// Step counter with programmable loop length.
//   clk, reset : clock and synchronous active-high reset
//   advance    : move to the next step (wrapping at len)
//   clear      : force step to 0 without a bar_done pulse
//   len_load   : capture len_in (0 or > STEPS is stored as STEPS)
//   step       : current step index
//   step_nxt   : index the next advance will produce (used for evaluation)
//   bar_done   : one-cycle pulse when an advance lands on step 0
module seq_step_counter import seq_pkg::*; #(
  parameter  int STEPS  = 8,
  localparam int STEP_W = step_w(STEPS),
  localparam int LEN_W  = STEP_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              clear,
  input  logic              len_load,
  input  logic [LEN_W-1:0]  len_in,
  output logic [STEP_W-1:0] step,
  output logic [STEP_W-1:0] step_nxt,
  output logic              bar_done
);

  logic [STEP_W-1:0] step_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_clean;
  logic [LEN_W-1:0]  step_inc;
  logic              bar_q;

  assign len_clean = ((len_in == '0) || (len_in > LEN_W'(STEPS))) ? LEN_W'(STEPS) : len_in;

  // Wrap on ">=" rather than "==" so a length shortened below the current
  // step still returns to 0 on the next advance.
  assign step_inc = {1'b0, step_q} + LEN_W'(1);
  assign step_nxt = (step_inc >= len_q) ? '0 : step_inc[STEP_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= '0;
      len_q  <= LEN_W'(STEPS);
      bar_q  <= 1'b0;
    end else begin
      bar_q <= 1'b0;
      if (len_load) begin
        len_q <= len_clean;
      end
      if (clear) begin
        step_q <= '0;
      end else if (advance) begin
        step_q <= step_nxt;
        bar_q  <= (step_nxt == '0);
      end
    end
  end

  assign step     = step_q;
  assign bar_done = bar_q;

endmodule

// File: rtl/step_sequencer.sv
// Multi-channel step sequencer: per-channel patterns, tempo and loop-length
// registers, a run/pause/stop FSM and registered trigger/gate outputs.
//   clk, reset : clock and synchronous active-high reset
//   bus        : seq_if slave modport (loads, transport, mute, outputs)
//
// state | meaning
// IDLE  | stopped, step held at 0, gates low
// RUN   | step_tick advances the step and re-evaluates trig/gate
// PAUSE | step held, gates low, step_tick ignored
module step_sequencer import seq_pkg::*; #(
  parameter int NUM_CH      = 4,
  parameter int STEPS       = 8,
  parameter int BPM_W       = 8,
  parameter int BPM_DEFAULT = DEFAULT_BPM
) (
  input  logic clk,
  input  logic reset,
  seq_if.slave bus
);

  localparam int STEP_W = step_w(STEPS);
  localparam int LEN_W  = STEP_W + 1;

  seq_state_e state, state_nxt;

  logic [STEPS-1:0]  pattern [NUM_CH];
  logic [BPM_W-1:0]  bpm_q;
  logic [NUM_CH-1:0] trig_q;
  logic [NUM_CH-1:0] gate_q;
  logic [NUM_CH-1:0] pat_col;
  logic [STEP_W-1:0] step_cur;
  logic [STEP_W-1:0] step_nxt;
  logic [STEP_W-1:0] eval_idx;
  logic              bar_done;
  logic              advance;
  logic              clear;
  logic              eval;
  logic              gate_keep;

  seq_step_counter #(.STEPS(STEPS)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .advance  (advance),
    .clear    (clear),
    .len_load (bus.ld_len),
    .len_in   (bus.sel[LEN_W-1:0]),
    .step     (step_cur),
    .step_nxt (step_nxt),
    .bar_done (bar_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // stop outranks play, and a play transition swallows a coincident tick.
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    clear     = 1'b0;
    eval      = 1'b0;
    eval_idx  = step_nxt;
    gate_keep = 1'b0;
    if (bus.stop) begin
      state_nxt = IDLE;
      clear     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.play) begin
            state_nxt = RUN;
            eval      = 1'b1;
            eval_idx  = '0;
          end
        end
        RUN: begin
          if (!bus.play) begin
            state_nxt = PAUSE;
          end else if (bus.step_tick) begin
            advance = 1'b1;
            eval    = 1'b1;
          end else begin
            gate_keep = 1'b1;
          end
        end
        PAUSE: begin
          if (bus.play) begin
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = IDLE;
          clear     = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    pat_col = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pat_col[i] = pattern[i][eval_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pattern[i] <= '0;
      end
      bpm_q <= BPM_W'(BPM_DEFAULT);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.ld_ch[i]) begin
          pattern[i] <= bus.sel;
        end
      end
      if (bus.ld_bpm) begin
        bpm_q <= bus.sel[BPM_W-1:0];
      end
    end
  end

  // Between evaluations a gate can only fall (mute), never rise again.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q <= '0;
      gate_q <= '0;
    end else if (eval) begin
      trig_q <= pat_col & ~bus.mute;
      gate_q <= pat_col & ~bus.mute;
    end else begin
      trig_q <= '0;
      gate_q <= gate_keep ? (gate_q & ~bus.mute) : '0;
    end
  end

  assign bus.trig     = trig_q;
  assign bus.gate     = gate_q;
  assign bus.step     = step_cur;
  assign bus.bar_done = bar_done;
  assign bus.bpm      = bpm_q;
  assign bus.running  = (state == RUN);

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  logic clk = 1'b0;
  logic reset;

  seq_if #(.NUM_CH(4), .STEPS(8), .BPM_W(8)) bus ();

  step_sequencer #(.NUM_CH(4), .STEPS(8), .BPM_W(8), .BPM_DEFAULT(120)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       play;
    logic       stop;
    logic       tick;
    logic [3:0] ld_ch;
    logic       ld_len;
    logic [7:0] sel;
    logic [3:0] mute;
    logic [3:0] e_trig;
    logic [3:0] e_gate;
    logic [2:0] e_step;
    logic       e_bar;
    logic       e_run;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int failures = 0;

  function automatic vec_t mk(input logic p, input logic s, input logic t,
                              input logic [3:0] lc, input logic ll, input logic [7:0] sl,
                              input logic [3:0] mu, input logic [3:0] et, input logic [3:0] eg,
                              input logic [2:0] es, input logic eb, input logic er);
    vec_t v;
    v.play = p; v.stop = s; v.tick = t; v.ld_ch = lc; v.ld_len = ll; v.sel = sl; v.mute = mu;
    v.e_trig = et; v.e_gate = eg; v.e_step = es; v.e_bar = eb; v.e_run = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.sel = '0; bus.ld_ch = '0; bus.ld_bpm = 1'b0; bus.ld_len = 1'b0;
    bus.play = 1'b0; bus.stop = 1'b0; bus.step_tick = 1'b0; bus.mute = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Packed status {trig, gate, step, bar_done, running}
  function automatic logic [31:0] status();
    return 32'({bus.trig, bus.gate, bus.step, bus.bar_done, bus.running});
  endfunction

  function automatic logic [31:0] pack_exp(input logic [3:0] t, input logic [3:0] g,
                                           input logic [2:0] s, input logic b, input logic r);
    return 32'({t, g, s, b, r});
  endfunction

  initial begin
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check("reset_status", status(), 32'h0);
    check("reset_bpm", 32'(bus.bpm), 32'd120);

    // ch0 = 1000_0001, full-length loop
    vecs.push_back(mk(0,0,0,4'h1,0,8'h81,4'h0, 4'h0,4'h0,3'd0,0,0));
    vecs.push_back(mk(1,0,0,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd0,0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd1,0,1));
    for (int s = 2; s <= 6; s++)
      vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'(s),0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd7,0,1));
    vecs.push_back(mk(1,0,0,4'h0,0,8'h00,4'h0, 4'h0,4'h1,3'd7,0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd0,1,1));
    vecs.push_back(mk(1,0,0,4'h0,0,8'h00,4'h0, 4'h0,4'h1,3'd0,0,1));
    vecs.push_back(mk(0,1,0,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd0,0,0));
    // len = 3
    vecs.push_back(mk(0,0,0,4'h0,1,8'h03,4'h0, 4'h0,4'h0,3'd0,0,0));
    vecs.push_back(mk(1,0,0,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd0,0,1));
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd1,0,1));
      vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd2,0,1));
      vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd0,1,1));
    end
    // len = 0 -> full 8 steps; loading mid-step keeps the gate
    vecs.push_back(mk(1,0,0,4'h0,1,8'h00,4'h0, 4'h0,4'h1,3'd0,0,1));
    for (int s = 1; s <= 6; s++)
      vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'(s),0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd7,0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd0,1,1));
    // run to step 5, then shrink len to 4
    for (int s = 1; s <= 5; s++)
      vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'(s),0,1));
    vecs.push_back(mk(1,0,0,4'h0,1,8'h04,4'h0, 4'h0,4'h0,3'd5,0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd0,1,1));
    for (int s = 1; s <= 3; s++)
      vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'(s),0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd0,1,1));
    vecs.push_back(mk(0,1,0,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd0,0,0));
    // len = 9 (> STEPS) is stored as 8; ch0 = 0001_1101
    vecs.push_back(mk(0,0,0,4'h0,1,8'h09,4'h0, 4'h0,4'h0,3'd0,0,0));
    vecs.push_back(mk(0,0,0,4'h1,0,8'h1D,4'h0, 4'h0,4'h0,3'd0,0,0));
    // pause at step 2, ticks ignored, resume without retrigger
    vecs.push_back(mk(1,0,0,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd0,0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd1,0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd2,0,1));
    vecs.push_back(mk(0,0,0,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd2,0,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0,1,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd2,0,0));
    vecs.push_back(mk(1,0,0,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd2,0,1));
    vecs.push_back(mk(1,0,0,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd2,0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd3,0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd4,0,1));
    // stop together with tick at step 4
    vecs.push_back(mk(1,1,1,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd0,0,0));
    vecs.push_back(mk(0,0,0,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd0,0,0));
    // tick on the IDLE->RUN edge is ignored
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'h1,4'h1,3'd0,0,1));
    vecs.push_back(mk(0,1,0,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd0,0,0));
    // mute ch1 with ch1/ch2 = FF
    vecs.push_back(mk(0,0,0,4'h1,0,8'h00,4'h0, 4'h0,4'h0,3'd0,0,0));
    vecs.push_back(mk(0,0,0,4'h6,0,8'hFF,4'h0, 4'h0,4'h0,3'd0,0,0));
    vecs.push_back(mk(1,0,0,4'h0,0,8'h00,4'h2, 4'h4,4'h4,3'd0,0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h2, 4'h4,4'h4,3'd1,0,1));
    vecs.push_back(mk(1,0,0,4'h0,0,8'h00,4'h6, 4'h0,4'h0,3'd1,0,1));
    vecs.push_back(mk(1,0,0,4'h0,0,8'h00,4'h2, 4'h0,4'h0,3'd1,0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h2, 4'h4,4'h4,3'd2,0,1));
    vecs.push_back(mk(0,1,0,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd0,0,0));
    // all channels = 0F
    vecs.push_back(mk(0,0,0,4'hF,0,8'h0F,4'h0, 4'h0,4'h0,3'd0,0,0));
    vecs.push_back(mk(1,0,0,4'h0,0,8'h00,4'h0, 4'hF,4'hF,3'd0,0,1));
    for (int s = 1; s <= 7; s++)
      vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, (s < 4) ? 4'hF : 4'h0, (s < 4) ? 4'hF : 4'h0, 3'(s),0,1));
    vecs.push_back(mk(1,0,1,4'h0,0,8'h00,4'h0, 4'hF,4'hF,3'd0,1,1));
    vecs.push_back(mk(0,1,0,4'h0,0,8'h00,4'h0, 4'h0,4'h0,3'd0,0,0));

    foreach (vecs[i]) begin
      bus.play = vecs[i].play; bus.stop = vecs[i].stop; bus.step_tick = vecs[i].tick;
      bus.ld_ch = vecs[i].ld_ch; bus.ld_len = vecs[i].ld_len; bus.sel = vecs[i].sel;
      bus.mute = vecs[i].mute; bus.ld_bpm = 1'b0;
      cycle();
      check($sformatf("vec%0d", i), status(),
            pack_exp(vecs[i].e_trig, vecs[i].e_gate, vecs[i].e_step, vecs[i].e_bar, vecs[i].e_run));
    end
    idle_inputs();

    // tempo load
    bus.ld_bpm = 1'b1; bus.sel = 8'h55;
    cycle();
    idle_inputs();
    check("bpm_load", 32'(bus.bpm), 32'h55);

    // reset mid-RUN clears everything, including patterns and tempo
    bus.play = 1'b1;
    cycle();
    bus.step_tick = 1'b1;
    cycle();
    bus.step_tick = 1'b0;
    check("pre_reset", status(), pack_exp(4'hF, 4'hF, 3'd1, 1'b0, 1'b1));
    reset = 1'b1;
    cycle();
    check("reset_mid_run", status(), 32'h0);
    check("reset_mid_run_bpm", 32'(bus.bpm), 32'd120);
    reset = 1'b0;
    cycle();
    check("post_reset_run", status(), pack_exp(4'h0, 4'h0, 3'd0, 1'b0, 1'b1));
    bus.step_tick = 1'b1;
    cycle();
    bus.step_tick = 1'b0;
    check("post_reset_tick", status(), pack_exp(4'h0, 4'h0, 3'd1, 1'b0, 1'b1));
    idle_inputs();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
